font_cell_engine: RTL and testbench
===================================

// Module: font_cell_engine
// PURPOSE
//  Parametrised successor to the 6x8-cell hex font engine. Tracks raster position as
//  character cell, glyph row and glyph column, with runtime integer zoom. Emits one
//  pixel bit per glyph (NUM_GLYPHS wide) for the current pixel.
//  Sits between the video timing generator and the overlay pixel mux.
// PARAMETERS
//  NUM_GLYPHS  16  glyphs driven on char_data, 1..16, taken from FONT_GLYPH[0..NUM_GLYPHS-1]
//  CX_W        7   width of char_x counter
//  CY_W        7   width of char_y counter
// PORTS
//  clk         in   1           pixel clock
//  reset       in   1           synchronous, active-high
//  blank       in   1           1 = outside active video
//  hsync       in   1           accepted for interface compatibility, unused
//  vsync       in   1           1 = vertical sync, restarts the frame
//  scale       in   2           zoom log2: 0=1x 1=2x 2=4x 3=8x
//  char_x      out  CX_W        cell column of current pixel
//  char_y      out  CY_W        cell row of current pixel
//  glyph_col   out  3           pixel column in cell, 0..5
//  glyph_row   out  3           pixel row in cell, 0..7
//  char_data   out  NUM_GLYPHS  glyph g pixel bit, 1 cycle after position outputs
//  char_valid  out  1           ~blank delayed 1 cycle, aligned with char_data
// BEHAVIOUR
//  - All state is cleared by reset: char_x, char_y, glyph_col, glyph_row, sub-counters,
//    scale_q, char_data and char_valid = 0. Reset mid-frame: y stays 0 until the next
//    line advance. Resync is by vsync.
//  - scale_q <= scale while vsync=1. It is constant for the whole frame. Z = 1<<scale_q.
//  - Horizontal, blank=1: xsub, glyph_col and char_x = 0.
//  - Horizontal, blank=0: xsub increments.
//    - When xsub==Z-1: xsub=0 and glyph_col advances.
//    - glyph_col 5 -> 0 and increments char_x. char_x wraps modulo 2^CX_W.
//  - Vertical, on the line advance (blank rising, blank & ~blank_d1): ysub increments.
//    - When ysub==Z-1: ysub=0 and glyph_row advances.
//    - glyph_row 7 -> 0 and increments char_y. char_y wraps modulo 2^CY_W.
//  - vsync=1: ysub, glyph_row and char_y = 0. vsync overrides a coincident line advance.
//  - Glyph lookup:
//    - bit index = (7-glyph_row)*6 + (5-glyph_col).
//    - Row 0 is the top (spacer) row; col 0 is the leftmost pixel.
//    - char_data[g] <= FONT_GLYPH[g][idx], registered, latency 1.
//  - char_data is not masked by blank; consumers gate with char_valid.
// CONFIGURATION
//  - FONT_SCALE_EN defined: zoom works as above.
//  - FONT_SCALE_EN undefined:
//    - scale port is ignored and scale_q is tied to 0 (Z=1).
//    - Sub-counters are removed; timing is identical to the original 1x engine.
// STRUCTURE
//  - font_pkg:
//    - localparams FONT_CELL_W=6, FONT_CELL_H=8.
//    - typedef logic [47:0] glyph_t.
//    - const glyph_t FONT_GLYPH[16], hex 0-F, MSB = top-left, row 0 blank.
//    - function glyph_bit_idx(row,col).
//  - Sub-module font_glyph_rom:
//    - inputs glyph_row and glyph_col; output NUM_GLYPHS registered bits.
//    - Parameter NUM_GLYPHS.
//  - font_cell_engine owns the counters, the scale latch and the char_valid delay.
// TESTING
//  1. Reset, vsync pulse, scale=0, 12 active pixels on line 0:
//     - char_data all 0 (spacer row).
//     - char_x 0 -> 1 after the 6th pixel.
//     - glyph_col cycles 0..5.
//  2. One blank pulse, then 6 active pixels (glyph_row=1):
//     - char_data[1] = 0,0,1,0,0,0, each one cycle after its position.
//     - char_data[0] = 0,1,1,1,0,0.
//  3. FONT_SCALE_EN, scale=1 at vsync:
//     - each glyph_col is held 2 clocks; char_x steps every 12 active clocks.
//     - glyph_row steps every 2 lines.
//     - Changing scale mid-frame has no effect until the next vsync.
//  4. vsync=1 in the same cycle as blank rising at glyph_row=7: glyph_row and char_y stay 0.
//  5. 129 cells on one line with CX_W=7: char_x wraps 127 -> 0.
//     Reset asserted mid-line: next cycle all outputs 0.
//  6. FONT_SCALE_EN undefined, scale=3: identical to the 1x results of scenario 1.

Source files
------------

// File: rtl/font_pkg.sv
// Shared font definitions: cell geometry, the 16-glyph hex font (0-F) and the glyph bit-index helper.
// Each glyph is 6x8 with the MSB at the top-left pixel; row 0 is an all-blank spacer row.
package font_pkg;

    localparam int FONT_CELL_W     = 6;
    localparam int FONT_CELL_H     = 8;
    localparam int FONT_NUM_GLYPHS = 16;

    typedef logic [47:0] glyph_t;

    // Eight 6-bit rows per glyph, top row first; the leftmost pixel is the high bit of each row.
    localparam glyph_t FONT_GLYPH [FONT_NUM_GLYPHS] = '{
        48'b000000_011100_100010_100110_101010_110010_100010_011100,  // 0
        48'b000000_001000_011000_001000_001000_001000_001000_011100,  // 1
        48'b000000_011100_100010_000010_000100_001000_010000_111110,  // 2
        48'b000000_111110_000100_001000_000100_000010_100010_011100,  // 3
        48'b000000_000100_001100_010100_100100_111110_000100_000100,  // 4
        48'b000000_111110_100000_111100_000010_000010_100010_011100,  // 5
        48'b000000_001100_010000_100000_111100_100010_100010_011100,  // 6
        48'b000000_111110_000010_000100_001000_010000_010000_010000,  // 7
        48'b000000_011100_100010_100010_011100_100010_100010_011100,  // 8
        48'b000000_011100_100010_100010_011110_000010_000100_011000,  // 9
        48'b000000_011100_100010_100010_100010_111110_100010_100010,  // A
        48'b000000_111100_100010_100010_111100_100010_100010_111100,  // B
        48'b000000_011100_100010_100000_100000_100000_100010_011100,  // C
        48'b000000_111000_100100_100010_100010_100010_100100_111000,  // D
        48'b000000_111110_100000_100000_111100_100000_100000_111110,  // E
        48'b000000_111110_100000_100000_111100_100000_100000_100000   // F
    };

    function automatic logic [5:0] glyph_bit_idx(input logic [2:0] row, input logic [2:0] col);
        return 6'((FONT_CELL_H - 1 - int'(row)) * FONT_CELL_W + (FONT_CELL_W - 1 - int'(col)));
    endfunction

endpackage

// File: rtl/font_glyph_rom.sv
// Registered glyph lookup: one pixel bit per glyph for the given glyph row/column, latency 1.
module font_glyph_rom
    import font_pkg::*;
#(
    parameter int NUM_GLYPHS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            glyph_row,
    input  logic [2:0]            glyph_col,
    output logic [NUM_GLYPHS-1:0] char_data
);

    logic [5:0]            bit_idx;
    logic [NUM_GLYPHS-1:0] pixel_bits;

    assign bit_idx = glyph_bit_idx(glyph_row, glyph_col);

    // NOTE: default the whole vector before the loop so no bit can hold its value (no latch).
    always_comb begin
        pixel_bits = '0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            pixel_bits[g] = FONT_GLYPH[g][bit_idx];
        end
    end

    // NOTE: only the output register is reset; the font table is a constant, not a memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_data <= '0;
        end else begin
            char_data <= pixel_bits;
        end
    end

endmodule

// File: rtl/font_cell_engine.sv
// Raster position tracker (cell, glyph row/column) feeding a registered hex-font lookup.
// Runtime integer zoom is built only when FONT_SCALE_EN is defined; otherwise it runs at fixed 1x.
module font_cell_engine
    import font_pkg::*;
#(
    parameter int NUM_GLYPHS = 16,
    parameter int CX_W       = 7,
    parameter int CY_W       = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blank,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [1:0]            scale,
    output logic [CX_W-1:0]       char_x,
    output logic [CY_W-1:0]       char_y,
    output logic [2:0]            glyph_col,
    output logic [2:0]            glyph_row,
    output logic [NUM_GLYPHS-1:0] char_data,
    output logic                  char_valid
);

    localparam logic [2:0] COL_LAST = 3'(FONT_CELL_W - 1);
    localparam logic [2:0] ROW_LAST = 3'(FONT_CELL_H - 1);

    logic blank_d1;
    logic line_adv;
    logic x_step;
    logic y_step;

    assign line_adv = blank & ~blank_d1;

`ifdef FONT_SCALE_EN
    logic [1:0] scale_q;
    logic [2:0] xsub;
    logic [2:0] ysub;
    logic [2:0] z_last;
    logic       unused_hsync;

    assign unused_hsync = hsync;
    assign z_last       = 3'((4'd1 << scale_q) - 4'd1);
    assign x_step       = (xsub == z_last);
    assign y_step       = (ysub == z_last);

    // Zoom is latched only during vsync so it stays fixed for the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            scale_q <= '0;
            xsub    <= '0;
            ysub    <= '0;
        end else begin
            if (vsync) scale_q <= scale;

            if (blank || x_step) xsub <= '0;
            else                 xsub <= xsub + 3'd1;

            if (vsync || (line_adv && y_step)) ysub <= '0;
            else if (line_adv)                 ysub <= ysub + 3'd1;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = &{1'b0, hsync, scale};
    assign x_step        = 1'b1;
    assign y_step        = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_d1   <= 1'b0;
            char_valid <= 1'b0;
            glyph_col  <= '0;
            char_x     <= '0;
            glyph_row  <= '0;
            char_y     <= '0;
        end else begin
            blank_d1   <= blank;
            char_valid <= ~blank;

            if (blank) begin
                glyph_col <= '0;
                char_x    <= '0;
            end else if (x_step) begin
                if (glyph_col == COL_LAST) begin
                    glyph_col <= '0;
                    char_x    <= char_x + CX_W'(1);
                end else begin
                    glyph_col <= glyph_col + 3'd1;
                end
            end

            // vsync wins over a line advance landing in the same cycle.
            if (vsync) begin
                glyph_row <= '0;
                char_y    <= '0;
            end else if (line_adv && y_step) begin
                if (glyph_row == ROW_LAST) begin
                    glyph_row <= '0;
                    char_y    <= char_y + CY_W'(1);
                end else begin
                    glyph_row <= glyph_row + 3'd1;
                end
            end
        end
    end

    font_glyph_rom #(
        .NUM_GLYPHS(NUM_GLYPHS)
    ) u_rom (
        .clk       (clk),
        .reset     (reset),
        .glyph_row (glyph_row),
        .glyph_col (glyph_col),
        .char_data (char_data)
    );

endmodule

// File: tb/tb_font_cell_engine.sv
// Self-checking bench for font_cell_engine: directed vector table, hand-written corner sequences,
// and randomized raster traffic compared against a pixel/line-count reference model.
`timescale 1ns/1ps
module tb_font_cell_engine;

    localparam int NUM_GLYPHS = 16;
    localparam int CX_W       = 7;
    localparam int CY_W       = 7;

`ifdef FONT_SCALE_EN
    localparam logic [1:0] TB_SCALE_1X = 2'd0;
`else
    localparam logic [1:0] TB_SCALE_1X = 2'd3;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  blank;
    logic                  hsync;
    logic                  vsync;
    logic [1:0]            scale;
    logic [CX_W-1:0]       char_x;
    logic [CY_W-1:0]       char_y;
    logic [2:0]            glyph_col;
    logic [2:0]            glyph_row;
    logic [NUM_GLYPHS-1:0] char_data;
    logic                  char_valid;

    font_cell_engine #(
        .NUM_GLYPHS(NUM_GLYPHS),
        .CX_W      (CX_W),
        .CY_W      (CY_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .blank      (blank),
        .hsync      (hsync),
        .vsync      (vsync),
        .scale      (scale),
        .char_x     (char_x),
        .char_y     (char_y),
        .glyph_col  (glyph_col),
        .glyph_row  (glyph_row),
        .char_data  (char_data),
        .char_valid (char_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference font as bitmap rows, top row first; leftmost pixel is bit 5.
    logic [5:0] tb_font [16][8];

    // Model state: active pixels since blank fell, line advances since vsync, latched zoom.
    int         m_px;
    int         m_ln;
    int         m_zlog;
    bit         m_blank_prev;
    logic [15:0] m_data;
    bit         m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int zoom();
`ifdef FONT_SCALE_EN
        return 1 << m_zlog;
`else
        return 1;
`endif
    endfunction

    function automatic int m_col();  return (m_px / zoom()) % 6;                          endfunction
    function automatic int m_x();    return (m_px / (6 * zoom())) % (1 << CX_W);          endfunction
    function automatic int m_row();  return (m_ln / zoom()) % 8;                          endfunction
    function automatic int m_y();    return (m_ln / (8 * zoom())) % (1 << CY_W);          endfunction

    task automatic model_update(input bit r, input bit b, input bit v, input logic [1:0] s);
        int  pre_row;
        int  pre_col;
        bit  adv;
        if (r) begin
            m_px = 0; m_ln = 0; m_zlog = 0; m_blank_prev = 0; m_data = '0; m_valid = 0;
        end else begin
            pre_row = m_row();
            pre_col = m_col();
            for (int g = 0; g < 16; g++) m_data[g] = tb_font[g][pre_row][5 - pre_col];
            m_valid      = !b;
            adv          = b && !m_blank_prev;
            m_blank_prev = b;
            m_px         = b ? 0 : m_px + 1;
            if (v) begin
                m_ln = 0;
`ifdef FONT_SCALE_EN
                m_zlog = int'(s);
`endif
            end else if (adv) begin
                m_ln++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".glyph_col"}, 32'(glyph_col), 32'(m_col()));
        check({tag, ".glyph_row"}, 32'(glyph_row), 32'(m_row()));
        check({tag, ".char_x"},    32'(char_x),    32'(m_x()));
        check({tag, ".char_y"},    32'(char_y),    32'(m_y()));
        check({tag, ".char_data"}, 32'(char_data), 32'(m_data));
        check({tag, ".char_valid"}, 32'(char_valid), 32'(m_valid));
    endtask

    // Drive one clock of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit r, input bit b, input bit v, input logic [1:0] s, input string tag);
        reset = r;
        blank = b;
        vsync = v;
        scale = s;
        hsync = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_update(r, b, v, s);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        bit              rst;
        bit              blk;
        bit              vs;
        logic [2:0]      col;
        logic [CX_W-1:0] x;
        logic [2:0]      row;
        logic [1:0]      data;
        bit              valid;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit blk, input bit vs, input int col,
                                input int x, input int row, input logic [1:0] data, input bit valid);
        vec_t v;
        v.rst = rst; v.blk = blk; v.vs = vs;
        v.col = 3'(col); v.x = CX_W'(x); v.row = 3'(row); v.data = data; v.valid = valid;
        return v;
    endfunction

    initial begin
        vec_t        tbl [$];
        logic [5:0]  one_r1;
        logic [5:0]  zero_r1;
        logic [1:0]  s;
        bit          coincide;
        int          act;

        tb_font = '{
            '{6'b000000, 6'b011100, 6'b100010, 6'b100110, 6'b101010, 6'b110010, 6'b100010, 6'b011100},
            '{6'b000000, 6'b001000, 6'b011000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b011100},
            '{6'b000000, 6'b011100, 6'b100010, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b111110},
            '{6'b000000, 6'b111110, 6'b000100, 6'b001000, 6'b000100, 6'b000010, 6'b100010, 6'b011100},
            '{6'b000000, 6'b000100, 6'b001100, 6'b010100, 6'b100100, 6'b111110, 6'b000100, 6'b000100},
            '{6'b000000, 6'b111110, 6'b100000, 6'b111100, 6'b000010, 6'b000010, 6'b100010, 6'b011100},
            '{6'b000000, 6'b001100, 6'b010000, 6'b100000, 6'b111100, 6'b100010, 6'b100010, 6'b011100},
            '{6'b000000, 6'b111110, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b010000, 6'b010000},
            '{6'b000000, 6'b011100, 6'b100010, 6'b100010, 6'b011100, 6'b100010, 6'b100010, 6'b011100},
            '{6'b000000, 6'b011100, 6'b100010, 6'b100010, 6'b011110, 6'b000010, 6'b000100, 6'b011000},
            '{6'b000000, 6'b011100, 6'b100010, 6'b100010, 6'b100010, 6'b111110, 6'b100010, 6'b100010},
            '{6'b000000, 6'b111100, 6'b100010, 6'b100010, 6'b111100, 6'b100010, 6'b100010, 6'b111100},
            '{6'b000000, 6'b011100, 6'b100010, 6'b100000, 6'b100000, 6'b100000, 6'b100010, 6'b011100},
            '{6'b000000, 6'b111000, 6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100100, 6'b111000},
            '{6'b000000, 6'b111110, 6'b100000, 6'b100000, 6'b111100, 6'b100000, 6'b100000, 6'b111110},
            '{6'b000000, 6'b111110, 6'b100000, 6'b100000, 6'b111100, 6'b100000, 6'b100000, 6'b100000}
        };

        reset = 1'b1; blank = 1'b1; vsync = 1'b0; hsync = 1'b0; scale = 2'd0;
        m_px = 0; m_ln = 0; m_zlog = 0; m_blank_prev = 0; m_data = '0; m_valid = 0;

        // Scenario 1/6: reset, vsync, 12 active pixels on the spacer row.
        one_r1  = 6'b001000;
        zero_r1 = 6'b011100;
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2'b00, 0));
        for (int k = 0; k < 12; k++) tbl.push_back(mk(0, 0, 0, (k + 1) % 6, (k + 1) / 6, 0, 2'b00, 1));
        // Scenario 2: one blank pulse, then glyph row 1 of '0' and '1'.
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 2'b00, 0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 0, 0, (k + 1) % 6, (k + 1) / 6, 1, {one_r1[5 - k], zero_r1[5 - k]}, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].blk, tbl[i].vs, TB_SCALE_1X, "tbl_model");
            check($sformatf("tbl[%0d].glyph_col", i), 32'(glyph_col), 32'(tbl[i].col));
            check($sformatf("tbl[%0d].char_x", i), 32'(char_x), 32'(tbl[i].x));
            check($sformatf("tbl[%0d].glyph_row", i), 32'(glyph_row), 32'(tbl[i].row));
            check($sformatf("tbl[%0d].char_data", i), 32'(char_data[1:0]), 32'(tbl[i].data));
            check($sformatf("tbl[%0d].char_valid", i), 32'(char_valid), 32'(tbl[i].valid));
        end

        // Scenario 4: vsync coincident with blank rising at glyph_row 7.
        step(0, 1, 1, 2'd0, "s4");
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 2'd0, "s4");
            step(0, 1, 0, 2'd0, "s4");
        end
        check("s4_row7", 32'(glyph_row), 32'd7);
        step(0, 0, 0, 2'd0, "s4");
        step(0, 1, 1, 2'd0, "s4");
        check("s4_vsync_row", 32'(glyph_row), 32'd0);
        check("s4_vsync_y", 32'(char_y), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 2'd0, "s4");
            step(0, 1, 0, 2'd0, "s4");
        end
        check("s4_wrap_row", 32'(glyph_row), 32'd0);
        check("s4_wrap_y", 32'(char_y), 32'd1);

        // Scenario 5: 129 cells on one line, then reset mid-line.
        step(0, 1, 1, 2'd0, "s5");
        step(0, 1, 0, 2'd0, "s5");
        for (int k = 1; k <= 129 * 6; k++) begin
            step(0, 0, 0, 2'd0, "s5");
            if (k == 127 * 6) check("s5_x127", 32'(char_x), 32'd127);
            if (k == 128 * 6) check("s5_x_wrap", 32'(char_x), 32'd0);
            if (k == 129 * 6) check("s5_x_after", 32'(char_x), 32'd1);
        end
        step(1, 0, 0, 2'd0, "s5_rst");
        check("s5_rst_col", 32'(glyph_col), 32'd0);
        check("s5_rst_x", 32'(char_x), 32'd0);
        check("s5_rst_row", 32'(glyph_row), 32'd0);
        check("s5_rst_y", 32'(char_y), 32'd0);
        check("s5_rst_data", 32'(char_data), 32'd0);
        check("s5_rst_valid", 32'(char_valid), 32'd0);
        step(0, 1, 0, 2'd0, "s5");

`ifdef FONT_SCALE_EN
        // Scenario 3: 2x zoom, and a mid-frame scale change that must not take effect.
        step(0, 1, 1, 2'd1, "s3");
        step(0, 1, 0, 2'd1, "s3");
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 2'd1, "s3");
            if (k == 1)  check("s3_col_hold", 32'(glyph_col), 32'd0);
            if (k == 2)  check("s3_col_step", 32'(glyph_col), 32'd1);
            if (k == 11) check("s3_x_before", 32'(char_x), 32'd0);
            if (k == 12) check("s3_x_step", 32'(char_x), 32'd1);
        end
        step(0, 1, 0, 2'd3, "s3");
        check("s3_row_hold", 32'(glyph_row), 32'd0);
        step(0, 0, 0, 2'd3, "s3");
        step(0, 0, 0, 2'd3, "s3");
        check("s3_midframe_col", 32'(glyph_col), 32'd1);
        step(0, 1, 0, 2'd3, "s3");
        check("s3_row_step", 32'(glyph_row), 32'd1);
        step(0, 0, 0, 2'd3, "s3");
        step(0, 1, 0, 2'd3, "s3");
        step(0, 0, 0, 2'd3, "s3");
        step(0, 1, 0, 2'd3, "s3");
        check("s3_row_4lines", 32'(glyph_row), 32'd2);
`else
        // Scenario 6 variant: scale=3 at vsync must still give 1x stepping.
        step(0, 1, 1, 2'd3, "s6");
        step(0, 1, 0, 2'd3, "s6");
        step(0, 0, 0, 2'd3, "s6");
        check("s6_col_1x", 32'(glyph_col), 32'd1);
        step(0, 1, 0, 2'd3, "s6");
        check("s6_row_1x", 32'(glyph_row), 32'd1);
`endif

        // Randomized frames against the model.
        for (int f = 0; f < 8; f++) begin
            s = 2'($urandom_range(0, 3));
            step(0, 1, 1, s, "rnd");
            step(0, 1, 0, 2'($urandom_range(0, 3)), "rnd");
            repeat ($urandom_range(10, 30)) begin
                act = $urandom_range(1, 80);
                repeat (act) step(($urandom_range(0, 299) == 0), 0, 0, 2'($urandom_range(0, 3)), "rnd");
                coincide = ($urandom_range(0, 9) == 0);
                step(0, 1, coincide, 2'($urandom_range(0, 3)), "rnd");
                repeat ($urandom_range(0, 4)) step(0, 1, 0, 2'($urandom_range(0, 3)), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
